// File: rtl/pw_attempt_ctrl.sv
// Password entry controller: compares a terminator-delimited character stream
// against a fixed password, counts consecutive failures and enforces a timed lockout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ENTRY   | accepting characters, char_ready high
// CHECK   | one cycle: evaluate the entry just terminated
// OPEN    | unlocked, waits for relock
// LOCKOUT | failure limit reached, down-counting the lockout timer
module pw_attempt_ctrl #(
  parameter int                    PW_LEN         = 4,
  parameter logic [8*PW_LEN-1:0]   PASSWORD       = 32'h48454C50,
  parameter logic [7:0]            TERM_CHAR      = 8'h0D,
  parameter int                    MAX_FAILS      = 3,
  parameter int                    LOCKOUT_CYCLES = 1000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [7:0]                     char_in,
  input  logic                           char_valid,
  output logic                           char_ready,
  input  logic                           relock,
  output logic                           open,
  output logic                           fail,
  output logic                           lockout,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

  localparam int IW = $clog2(PW_LEN + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [IW-1:0] IDX_FULL  = IW'(PW_LEN);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
  localparam logic [TW-1:0] TMR_LOAD  = TW'(LOCKOUT_CYCLES);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CHECK   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic          match, match_nx;
  logic [FW-1:0] fail_cnt_q, fail_cnt_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          fail_q, fail_nx;
  logic [7:0]    pw_byte;

  // Byte idx of the password, first character in the MSB byte
  always_comb begin
    pw_byte = 8'h00;
    for (int i = 0; i < PW_LEN; i++) begin
      if (idx == IW'(i)) pw_byte = PASSWORD[8*(PW_LEN-1-i) +: 8];
    end
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    match_nx    = match;
    fail_cnt_nx = fail_cnt_q;
    timer_nx    = timer;
    fail_nx     = 1'b0;
    case (state)
      ENTRY: begin
        if (char_valid) begin
          if (char_in == TERM_CHAR) begin
            state_nx = CHECK;
          end else if (idx == IDX_FULL) begin
            match_nx = 1'b0;
          end else begin
            if (char_in != pw_byte) match_nx = 1'b0;
            idx_nx = idx + IW'(1);
          end
        end
      end
      CHECK: begin
        match_nx = 1'b1;
        idx_nx   = '0;
        if (match && (idx == IDX_FULL)) begin
          state_nx    = OPEN;
          fail_cnt_nx = '0;
        end else begin
          fail_nx     = 1'b1;
          fail_cnt_nx = fail_cnt_q + FW'(1);
          if (fail_cnt_q == FAIL_LAST) begin
            state_nx = LOCKOUT;
            timer_nx = TMR_LOAD;
          end else begin
            state_nx = ENTRY;
          end
        end
      end
      OPEN: begin
        if (relock) state_nx = ENTRY;
      end
      LOCKOUT: begin
        timer_nx = timer - TMR_ONE;
        // <= guards against a corrupted timer sticking in lockout forever
        if (timer <= TMR_ONE) begin
          state_nx    = ENTRY;
          fail_cnt_nx = '0;
          timer_nx    = '0;
        end
      end
      default: state_nx = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ENTRY;
      idx        <= '0;
      match      <= 1'b1;
      fail_cnt_q <= '0;
      timer      <= '0;
      fail_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      match      <= match_nx;
      fail_cnt_q <= fail_cnt_nx;
      timer      <= timer_nx;
      fail_q     <= fail_nx;
    end
  end

  assign char_ready = (state == ENTRY);
  assign open       = (state == OPEN);
  assign lockout    = (state == LOCKOUT);
  assign fail       = fail_q;
  assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_pw_attempt_ctrl.sv
// Directed bench for pw_attempt_ctrl: password "HELP", CR terminator,
// three failures to lockout, 1000-cycle lockout.
module tb_pw_attempt_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       relock;
  logic       open;
  logic       fail;
  logic       lockout;
  logic [1:0] fail_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int fail_cycles = 0;

  localparam logic [7:0] CR = 8'h0D;

  pw_attempt_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .relock     (relock),
    .open       (open),
    .fail       (fail),
    .lockout    (lockout),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (fail) fail_cycles++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c);
    char_in    = c;
    char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  // Entry + CR, then run through CHECK so the result is visible
  task automatic do_entry(input string s);
    send_str(s);
    send_char(CR);
    tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    char_in = 8'h00; char_valid = 1'b0; relock = 1'b0;
    pulse_reset();
    n_checks++;
    if ({open, fail, lockout, char_ready, fail_cnt} !== 6'b000100) begin
      n_fail++;
      $display("FAIL reset_state: got open/fail/lock/rdy/cnt=%b%b%b%b/%0d required 0001/0",
               open, fail, lockout, char_ready, fail_cnt);
    end
  endtask

  task automatic test_open();
    int f0;
    f0 = fail_cycles;
    send_str("HELP");
    send_char(CR);
    n_checks++;
    if (open !== 1'b0 || char_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL check_cycle: got open=%b ready=%b required open=0 ready=0", open, char_ready);
    end
    tick();
    n_checks++;
    if (open !== 1'b1 || fail_cnt !== 2'd0 || char_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL open_pass: got open=%b cnt=%0d ready=%b required 1/0/0", open, fail_cnt, char_ready);
    end
    tick();
    n_checks++;
    if (fail_cycles !== f0) begin
      n_fail++;
      $display("FAIL open_no_fail: got %0d fail cycles required 0", fail_cycles - f0);
    end
    relock = 1'b1;
    tick();
    relock = 1'b0;
    n_checks++;
    if (open !== 1'b0 || char_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL relock: got open=%b ready=%b required 0/1", open, char_ready);
    end
  endtask

  task automatic test_lockout();
    int n;
    int bad_ready;
    do_entry("HELX");
    n_checks++;
    if (fail !== 1'b1 || fail_cnt !== 2'd1 || char_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fail1: got fail=%b cnt=%0d ready=%b required 1/1/1", fail, fail_cnt, char_ready);
    end
    tick();
    n_checks++;
    if (fail !== 1'b0) begin
      n_fail++;
      $display("FAIL fail1_width: got fail=%b required 0", fail);
    end
    do_entry("HELPS");
    n_checks++;
    if (fail !== 1'b1 || fail_cnt !== 2'd2) begin
      n_fail++;
      $display("FAIL fail2: got fail=%b cnt=%0d required 1/2", fail, fail_cnt);
    end
    tick();
    do_entry("");
    n_checks++;
    if (fail !== 1'b1 || fail_cnt !== 2'd3 || lockout !== 1'b1 || char_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fail3_lock: got fail=%b cnt=%0d lock=%b ready=%b required 1/3/1/0",
               fail, fail_cnt, lockout, char_ready);
    end
    char_in = "H"; char_valid = 1'b1;
    n = 0; bad_ready = 0;
    while (lockout === 1'b1 && n < 2000) begin
      if (char_ready !== 1'b0) bad_ready++;
      n++;
      tick();
    end
    char_valid = 1'b0;
    n_checks++;
    if (n !== 1000) begin
      n_fail++;
      $display("FAIL lockout_len: got %0d cycles required 1000", n);
    end
    n_checks++;
    if (bad_ready !== 0) begin
      n_fail++;
      $display("FAIL lockout_ready: got %0d cycles with ready high required 0", bad_ready);
    end
    n_checks++;
    if (char_ready !== 1'b1 || fail_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL lockout_exit: got ready=%b cnt=%0d required 1/0", char_ready, fail_cnt);
    end
    do_entry("HELP");
    n_checks++;
    if (open !== 1'b1) begin
      n_fail++;
      $display("FAIL open_after_lockout: got open=%b required 1", open);
    end
    relock = 1'b1; tick(); relock = 1'b0;
  endtask

  task automatic test_fail_clear();
    do_entry("");
    tick();
    do_entry("HE");
    tick();
    n_checks++;
    if (fail_cnt !== 2'd2) begin
      n_fail++;
      $display("FAIL two_fails: got cnt=%0d required 2", fail_cnt);
    end
    do_entry("HELP");
    n_checks++;
    if (open !== 1'b1 || fail_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL pass_clears: got open=%b cnt=%0d required 1/0", open, fail_cnt);
    end
    relock = 1'b1; tick(); relock = 1'b0;
    do_entry("HELLO");
    n_checks++;
    if (fail !== 1'b1 || fail_cnt !== 2'd1 || lockout !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_after_pass: got fail=%b cnt=%0d lock=%b required 1/1/0", fail, fail_cnt, lockout);
    end
    tick();
    pulse_reset();
  endtask

  task automatic test_hold_valid();
    send_str("HELP");
    char_in = CR; char_valid = 1'b1;
    tick();
    char_in = "H";
    tick();
    n_checks++;
    if (open !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_open: got open=%b required 1", open);
    end
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (open !== 1'b1 || char_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL open_ignores: got open=%b ready=%b required 1/0", open, char_ready);
    end
    relock = 1'b1;
    tick();
    relock = 1'b0;
    // 'H' still held: it transfers exactly once on this edge
    tick();
    char_valid = 1'b0;
    do_entry("ELP");
    n_checks++;
    if (open !== 1'b1) begin
      n_fail++;
      $display("FAIL held_char_once: got open=%b required 1", open);
    end
    relock = 1'b1; tick(); relock = 1'b0;
  endtask

  task automatic test_reset_cases();
    send_str("HE");
    pulse_reset();
    do_entry("HELP");
    n_checks++;
    if (open !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_entry: got open=%b required 1", open);
    end
    pulse_reset();
    n_checks++;
    if (open !== 1'b0 || char_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_open: got open=%b ready=%b required 0/1", open, char_ready);
    end
    do_entry("");
    tick();
    send_str("HX");
    send_char(CR);
    pulse_reset();
    n_checks++;
    if ({open, fail, lockout, char_ready, fail_cnt} !== 6'b000100) begin
      n_fail++;
      $display("FAIL reset_in_check: got open/fail/lock/rdy/cnt=%b%b%b%b/%0d required 0001/0",
               open, fail, lockout, char_ready, fail_cnt);
    end
    do_entry(""); tick();
    do_entry(""); tick();
    do_entry("");
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (lockout !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_before_reset: got lock=%b required 1", lockout);
    end
    pulse_reset();
    n_checks++;
    if ({open, fail, lockout, char_ready, fail_cnt} !== 6'b000100) begin
      n_fail++;
      $display("FAIL reset_in_lockout: got open/fail/lock/rdy/cnt=%b%b%b%b/%0d required 0001/0",
               open, fail, lockout, char_ready, fail_cnt);
    end
    do_entry("HELP");
    n_checks++;
    if (open !== 1'b1) begin
      n_fail++;
      $display("FAIL open_after_reset: got open=%b required 1", open);
    end
    relock = 1'b1; tick(); relock = 1'b0;
  endtask

  task automatic test_gap();
    send_str("HE");
    for (int i = 0; i < 5; i++) tick();
    do_entry("LP");
    n_checks++;
    if (open !== 1'b1 || fail_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_gap: got open=%b cnt=%0d required 1/0", open, fail_cnt);
    end
    relock = 1'b1; tick(); relock = 1'b0;
    do_entry("HELPHELP");
    n_checks++;
    if (fail !== 1'b1 || open !== 1'b0) begin
      n_fail++;
      $display("FAIL overlong: got fail=%b open=%b required 1/0", fail, open);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; char_in = 8'h00; char_valid = 1'b0; relock = 1'b0;
    tick();
    test_reset();
    test_open();
    test_lockout();
    test_fail_clear();
    test_hold_valid();
    test_reset_cases();
    test_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
